// File: rtl/audio_dai_pkg.sv
// Shared constants and FSM state encoding for the audio DAI transmitter.
package audio_dai_pkg;

   localparam int MODE_I2S = 0;
   localparam int MODE_LJ  = 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: free-runs while run is high and flags the last clk of
// each BCLK period, which is where serial outputs are allowed to change.
module audio_bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bclk,
   output logic fall
);

   localparam int CNT_W = $clog2(BCLK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BCLK_DIV - 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(BCLK_DIV / 2);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = '0;
      if (run && (cnt != LAST)) cnt_next = cnt + 1'b1;
   end

   assign fall = run && (cnt == LAST);

   // bclk is decoded from the next count so it stays a clean flop output
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         bclk <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         bclk <= (cnt_next >= HALF);
      end
   end

endmodule

// File: rtl/audio_dai_tx.sv
// Stereo DAI transmitter: one-entry (L,R) holding buffer feeding a frame
// shifter, serialised as I2S or left-justified on a divided bit clock.
module audio_dai_tx
   import audio_dai_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 4,
   parameter int MODE     = MODE_I2S
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              aud_bclk,
   output logic              aud_lrck,
   output logic              aud_dacdat,
   output logic              frame_start,
   output logic              underrun,
   output state_t            fsm_state
);

   localparam int FRAME_W = 2 * SLOT_W;
   localparam int BIT_W   = $clog2(FRAME_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
   localparam logic [BIT_W-1:0] SLOT_IDX = BIT_W'(SLOT_W);
   localparam bit   IS_LJ     = (MODE == MODE_LJ);
   localparam logic LRCK_IDLE = IS_LJ ? 1'b0 : 1'b1;

   function automatic logic [FRAME_W-1:0] frame_image(input logic [DATA_W-1:0] l,
                                                      input logic [DATA_W-1:0] r);
      logic [FRAME_W-1:0] img;
      img = '0;
      img[FRAME_W-1 -: DATA_W] = l;
      img[SLOT_W-1 -: DATA_W]  = r;
      return img;
   endfunction

   state_t             state;
   state_t             state_next;
   logic [BIT_W-1:0]   bit_cnt;
   logic [BIT_W-1:0]   bit_inc;
   logic [FRAME_W-1:0] shreg;
   logic [FRAME_W-1:0] load_image;
   logic [DATA_W-1:0]  buf_l;
   logic [DATA_W-1:0]  buf_r;
   logic               fall;
   logic               frame_end;
   logic               accept;
   logic               load;

   audio_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
      .clk   (clk),
      .reset (reset),
      .run   (state == RUN),
      .bclk  (aud_bclk),
      .fall  (fall)
   );

   // Handshake: a pair transfers on any clk where s_valid && s_ready; s_ready
   // is simply "holding buffer empty" and never depends on s_valid.
   assign accept     = s_valid && s_ready;
   assign frame_end  = fall && (bit_cnt == LAST_BIT);
   assign bit_inc    = bit_cnt + 1'b1;
   assign load_image = s_ready ? '0 : frame_image(buf_l, buf_r);
   assign fsm_state  = state;

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !s_ready) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         RUN: begin
            if (frame_end) begin
               if (enable) load = 1'b1;
               else        state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         buf_l       <= '0;
         buf_r       <= '0;
         s_ready     <= 1'b1;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         aud_lrck    <= LRCK_IDLE;
         aud_dacdat  <= 1'b0;
      end else begin
         state       <= state_next;
         frame_start <= load;
         underrun    <= load && s_ready;

         // A same-clk accept wins: the shifter takes the old pair, the new one stays
         if (accept) begin
            buf_l   <= s_left;
            buf_r   <= s_right;
            s_ready <= 1'b0;
         end else if (load) begin
            s_ready <= 1'b1;
         end

         if (state_next == IDLE) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            aud_lrck   <= LRCK_IDLE;
            aud_dacdat <= 1'b0;
         end else if (load) begin
            bit_cnt    <= '0;
            shreg      <= load_image;
            aud_lrck   <= 1'b0;
            // I2S runs one bit behind the slot, so it still owes the previous last bit
            aud_dacdat <= IS_LJ ? load_image[FRAME_W-1] : shreg[FRAME_W-1];
         end else if (fall) begin
            bit_cnt    <= bit_inc;
            shreg      <= {shreg[FRAME_W-2:0], 1'b0};
            aud_lrck   <= (bit_inc >= SLOT_IDX);
            aud_dacdat <= IS_LJ ? shreg[FRAME_W-2] : shreg[FRAME_W-1];
         end
      end
   end

endmodule

// File: tb/tb_audio_dai_tx.sv
// Bench for audio_dai_tx: an LJ and an I2S instance share one stimulus stream;
// both serial outputs are deserialised and scored against expected frames.
module tb_audio_dai_tx;
   import audio_dai_pkg::*;

   localparam int DATA_W    = 16;
   localparam int SLOT_W    = 32;
   localparam int BCLK_DIV  = 4;
   localparam int FRAME_CLK = 2 * SLOT_W * BCLK_DIV;
   localparam logic [63:0] LRCK_PAT = 64'h0000_0000_FFFF_FFFF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic s_valid = 1'b0;
   logic [DATA_W-1:0] s_left = '0;
   logic [DATA_W-1:0] s_right = '0;
   logic [1:0] ready_w, bclk_w, lrck_w, dat_w, fs_w, ur_w;
   state_t state_lj, state_i2s;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   audio_dai_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .MODE(MODE_LJ)) dut_lj (
      .clk(clk), .reset(reset), .enable(enable),
      .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(ready_w[0]),
      .aud_bclk(bclk_w[0]), .aud_lrck(lrck_w[0]), .aud_dacdat(dat_w[0]),
      .frame_start(fs_w[0]), .underrun(ur_w[0]), .fsm_state(state_lj)
   );

   audio_dai_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .MODE(MODE_I2S)) dut_i2s (
      .clk(clk), .reset(reset), .enable(enable),
      .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(ready_w[1]),
      .aud_bclk(bclk_w[1]), .aud_lrck(lrck_w[1]), .aud_dacdat(dat_w[1]),
      .frame_start(fs_w[1]), .underrun(ur_w[1]), .fsm_state(state_i2s)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int n_acc = 0;
   logic [63:0] exp_q0[$];
   logic [63:0] exp_q1[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   int unsigned cyc = 0;
   int idx[2] = '{0, 0};
   int n_fs[2] = '{0, 0};
   int n_ur[2] = '{0, 0};
   logic [63:0] dcap[2];
   logic [63:0] lcap[2];
   logic [1:0] bclk_prev = 2'b00;
   int unsigned fs_q[$];

   task automatic frame_done(input int m);
      logic [63:0] exp;
      if (m == 0) begin
         if (exp_q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL lj_unexpected_frame: got %h expected none", dcap[0]);
         end else begin
            exp = exp_q0.pop_front();
            check("lj_frame_data", dcap[0], exp);
            check("lj_lrck_pattern", lcap[0], LRCK_PAT);
         end
      end else begin
         if (exp_q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL i2s_unexpected_frame: got %h expected none", dcap[1]);
         end else begin
            exp = exp_q1.pop_front();
            // first captured bit belongs to the previous frame in I2S
            check("i2s_frame_data", {1'b0, dcap[1][62:0]}, {1'b0, exp[63:1]});
            check("i2s_lrck_pattern", lcap[1], LRCK_PAT);
         end
      end
   endtask

   // Deserialiser: capture data and word select on every BCLK rising edge
   always @(negedge clk) begin
      cyc++;
      for (int m = 0; m < 2; m++) begin
         if (fs_w[m]) begin
            idx[m] = 0;
            n_fs[m]++;
            if (m == 0) fs_q.push_back(cyc);
         end
         if (ur_w[m]) n_ur[m]++;
         if (bclk_w[m] && !bclk_prev[m]) begin
            dcap[m] = {dcap[m][62:0], dat_w[m]};
            lcap[m] = {lcap[m][62:0], lrck_w[m]};
            idx[m]++;
            if (idx[m] == 64) frame_done(m);
         end
         bclk_prev[m] = bclk_w[m];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [63:0] img);
      int t;
      s_left  = l;
      s_right = r;
      s_valid = 1'b1;
      t = 0;
      while (!ready_w[0] && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("send_ready", ready_w[0], 1'b1);
      @(negedge clk);
      n_acc++;
      exp_q0.push_back(img);
      exp_q1.push_back(img);
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!ready_w[0] && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("wait_ready", ready_w[0], 1'b1);
   endtask

   task automatic wait_fs(input int n);
      int seen;
      seen = 0;
      for (int t = 0; t < 1000 && seen < n; t++) begin
         @(negedge clk);
         if (fs_w[0]) seen++;
      end
      check("wait_frame_start", seen, n);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("drain_left", exp_q0.size() + exp_q1.size(), 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_lj_outs"},
            {ready_w[0], bclk_w[0], lrck_w[0], dat_w[0], fs_w[0], ur_w[0]}, 6'b100000);
      check({tag, "_i2s_outs"},
            {ready_w[1], bclk_w[1], lrck_w[1], dat_w[1], fs_w[1], ur_w[1]}, 6'b101000);
      check({tag, "_state"}, {state_lj, state_i2s}, {IDLE, IDLE});
   endtask

   task automatic check_bclk_quiet(input string tag);
      int highs;
      highs = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (bclk_w != 2'b00) highs++;
      end
      check(tag, highs, 0);
   endtask

   // ---------------- stimulus table ----------------
   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
      logic [63:0] img;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int fs0, acc0, ur_lj0, ur_i2s0;

      vecs[0] = '{16'hA5A5, 16'h0001, 64'hA5A5_0000_0001_0000};
      vecs[1] = '{16'h8000, 16'h7FFF, 64'h8000_0000_7FFF_0000};
      vecs[2] = '{16'hFFFF, 16'h8001, 64'hFFFF_0000_8001_0000};
      vecs[3] = '{16'h1234, 16'hFEDC, 64'h1234_0000_FEDC_0000};

      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;
      @(negedge clk);

      // Continuous stream with s_valid held high: one accept per frame
      fs_q.delete();
      fs0 = n_fs[0]; acc0 = n_acc; ur_lj0 = n_ur[0]; ur_i2s0 = n_ur[1];
      enable = 1'b1;
      for (int i = 0; i < 4; i++) send(vecs[i].l, vecs[i].r, vecs[i].img);
      s_valid = 1'b0;
      wait_ready();
      enable = 1'b0;
      wait_drain();
      repeat (4) @(negedge clk);
      check_idle("after_table");
      check_bclk_quiet("table_idle_bclk");
      check("table_frames", n_fs[0] - fs0, 4);
      check("table_accepts", n_acc - acc0, 4);
      check("table_underrun", (n_ur[0] - ur_lj0) + (n_ur[1] - ur_i2s0), 0);
      for (int i = 0; i + 1 < fs_q.size(); i++)
         check("frame_period", fs_q[i+1] - fs_q[i], FRAME_CLK);

      // Underrun: one pair, then nothing -> a zero frame and one underrun pulse
      ur_lj0 = n_ur[0]; ur_i2s0 = n_ur[1];
      enable = 1'b1;
      send(16'h5A5A, 16'hC003, 64'h5A5A_0000_C003_0000);
      s_valid = 1'b0;
      exp_q0.push_back(64'h0);
      exp_q1.push_back(64'h0);
      wait_fs(2);
      enable = 1'b0;
      wait_drain();
      repeat (4) @(negedge clk);
      check("underrun_lj", n_ur[0] - ur_lj0, 1);
      check("underrun_i2s", n_ur[1] - ur_i2s0, 1);
      check_idle("after_underrun");

      // Enable dropped at bit 10: frame still completes, then IDLE
      ur_lj0 = n_ur[0];
      enable = 1'b1;
      send(16'h0F0F, 16'hF0F0, 64'h0F0F_0000_F0F0_0000);
      s_valid = 1'b0;
      wait_fs(1);
      repeat (10 * BCLK_DIV) @(negedge clk);
      enable = 1'b0;
      wait_drain();
      repeat (4) @(negedge clk);
      check_idle("after_bit10_stop");
      check_bclk_quiet("bit10_idle_bclk");
      check("bit10_underrun", n_ur[0] - ur_lj0, 0);

      // Reset at bit 40 with a pair waiting in the buffer
      enable = 1'b1;
      send(16'h7E7E, 16'h0101, 64'h7E7E_0000_0101_0000);
      s_valid = 1'b0;
      wait_fs(1);
      send(16'h3333, 16'h4444, 64'h3333_0000_4444_0000);
      s_valid = 1'b0;
      check("buffer_full_before_reset", ready_w, 2'b00);
      repeat (40 * BCLK_DIV - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle("reset_mid_frame");
      reset = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      fs0 = n_fs[0];
      repeat (20) @(negedge clk);
      check("no_start_after_reset", n_fs[0] - fs0, 0);
      enable = 1'b0;
      repeat (4) @(negedge clk);

      check("queue_left", exp_q0.size() + exp_q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/audio_dai_tx.md
AUDIO_DAI_TX -- requirements
Module: audio_dai_tx

Interface
REQ-001 Parameter DATA_W, default 16, sample width per channel; legal range 8..32.
REQ-002 Parameter SLOT_W, default 32, BCLK periods per channel slot; SLOT_W SHALL be >= DATA_W.
REQ-003 Parameter BCLK_DIV, default 4, clk cycles per BCLK period; even, >= 2.
REQ-004 Parameter MODE, default MODE_I2S, frame format: MODE_I2S or MODE_LJ (left-justified).
REQ-005 clk  in  1  single clock for all logic; all outputs are registered on it.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  run request, sampled every clk.
REQ-008 s_left  in  DATA_W  left sample, two's complement.
REQ-009 s_right  in  DATA_W  right sample, two's complement.
REQ-010 s_valid  in  1  sample pair valid.
REQ-011 s_ready  out  1  holding buffer empty; pair accepted when s_valid & s_ready.
REQ-012 aud_bclk  out  1  bit clock to codec.
REQ-013 aud_lrck  out  1  word select; 0 = left, 1 = right.
REQ-014 aud_dacdat  out  1  serial data, MSB first.
REQ-015 frame_start  out  1  one-clk pulse when a frame is loaded into the shifter.
REQ-016 underrun  out  1  one-clk pulse when a frame is loaded with an empty holding buffer.

Function
REQ-017 Datapath SHALL be a one-entry holding buffer (L,R) feeding a 2*SLOT_W-bit shift register.
REQ-018 Holding buffer SHALL accept on s_valid & s_ready; s_ready SHALL deassert the clk after acceptance and reassert the clk after the buffer is copied to the shifter.
REQ-019 BCLK counter SHALL run 0..BCLK_DIV-1 while RUN; aud_bclk = 1 when count >= BCLK_DIV/2, else 0.
REQ-020 Fall strobe SHALL be count == BCLK_DIV-1; aud_dacdat, aud_lrck and bit counter change only on the fall strobe, so the codec samples on the BCLK rising edge.
REQ-021 Bit counter SHALL run 0..2*SLOT_W-1 and wrap to 0; the wrap is the frame boundary.
REQ-022 Shifter load image: {L, zeros(SLOT_W-DATA_W), R, zeros(SLOT_W-DATA_W)}; padding bits transmit 0.
REQ-023 MODE_LJ: aud_lrck = (bit counter >= SLOT_W); MSB of each channel coincides with the LRCK transition.
REQ-024 MODE_I2S: aud_lrck transitions one BCLK period before the MSB of each channel (MSB one BCLK after the LRCK edge).
REQ-025 At each frame boundary, if the holding buffer is full the shifter SHALL load it; if empty it SHALL load all zeros and pulse underrun.
REQ-026 States: IDLE, RUN. IDLE -> RUN when enable = 1 and the holding buffer is full; that cycle loads the shifter, sets the bit counter and BCLK counter to 0, and pulses frame_start.
REQ-027 RUN -> IDLE at the frame boundary when enable = 0; a frame already started SHALL always complete.
REQ-028 In IDLE: aud_bclk = 0, aud_dacdat = 0, aud_lrck = 0 (MODE_LJ) or 1 (MODE_I2S); acceptance into the holding buffer remains allowed.
REQ-029 Acceptance and frame load in the same clk: the load SHALL take the old buffer contents, the new pair SHALL occupy the buffer, and s_ready SHALL stay 0.
REQ-030 Maximum latency from acceptance to MSB output is one frame plus one BCLK period.

Reset
REQ-031 On reset: state IDLE, counters 0, shifter and holding buffer cleared, s_ready = 1, frame_start = 0, underrun = 0, and outputs per REQ-028.
REQ-032 Reset asserted mid-frame SHALL abort the frame on the next clk with no partial-bit completion.

Structure
REQ-033 Package audio_dai_pkg SHALL hold the MODE_I2S = 0 and MODE_LJ = 1 constants and the state enumeration.
REQ-034 Sub-module audio_bclk_gen (parameter BCLK_DIV) SHALL generate aud_bclk and the fall strobe; the top level holds the FSM, buffer and shifter.

Verification (DATA_W=16, SLOT_W=32, BCLK_DIV=4)
REQ-035 MODE_LJ, L=16'hA5A5, R=16'h0001, enable=1 -> deserialised frame {A5A5,0000,0001,0000}, lrck period 256 clk.
REQ-036 MODE_I2S, same pair -> MSB 1 BCLK after each lrck edge, L and R recovered exactly.
REQ-037 Start a frame with no further s_valid -> next frame transmits all zeros with a single underrun pulse.
REQ-038 s_valid held high -> exactly one acceptance per frame, frame_start every 256 clk, no underrun.
REQ-039 Drop enable at bit 10 -> frame completes, IDLE at the boundary, bclk held 0.
REQ-040 Assert reset at bit 40 -> next clk all outputs at reset values, s_ready = 1.
